// File: rtl/axis_sram_reader.sv
// SRAM-to-AXI-Stream egress engine: streams out_size elements, LANES per beat, from the output
// SRAM through a credit-controlled prefetch FIFO that hides the SRAM read latency.
module axis_sram_reader #(
   parameter int ADDR_WIDTH         = 13,
   parameter int DATA_WIDTH         = 8,
   parameter int LANES              = 4,
   parameter int SRAM_LATENCY       = 1,
   parameter int FIFO_DEPTH         = 4,
   parameter int NUM_CHANNELS_WIDTH = 7,
   parameter int SIZE_WIDTH         = ADDR_WIDTH + $clog2(LANES) + 1
) (
   input  logic                          m_axis_aclk,
   input  logic                          m_axis_aresetn,
   input  logic                          start,
   input  logic [ADDR_WIDTH-1:0]         base_addr,
   input  logic [SIZE_WIDTH-1:0]         out_size,
   input  logic [NUM_CHANNELS_WIDTH-1:0] num_channels,
   output logic                          busy,
   output logic                          done,
   output logic                          sram_rd_en,
   output logic [ADDR_WIDTH-1:0]         sram_rd_addr,
   input  logic [DATA_WIDTH*LANES-1:0]   sram_rd_data,
   output logic [DATA_WIDTH*LANES-1:0]   m_axis_tdata,
   output logic [LANES-1:0]              m_axis_tkeep,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic [NUM_CHANNELS_WIDTH-1:0] m_axis_tuser
);

   localparam int WORD_W     = DATA_WIDTH * LANES;
   localparam int LANE_SHIFT = $clog2(LANES);
   localparam int BEAT_W     = SIZE_WIDTH + 1;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;
   localparam int OCC_W      = $clog2(FIFO_DEPTH + SRAM_LATENCY + 1) + 1;
   localparam int CH_W       = NUM_CHANNELS_WIDTH + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   typedef struct packed {
      logic                          last;
      logic [LANES-1:0]              keep;
      logic [NUM_CHANNELS_WIDTH-1:0] user;
   } tag_t;

   typedef struct packed {
      logic [WORD_W-1:0]             data;
      logic [LANES-1:0]              keep;
      logic                          last;
      logic [NUM_CHANNELS_WIDTH-1:0] user;
   } entry_t;

   logic [1:0]                    state;
   logic [ADDR_WIDTH-1:0]         rd_addr;
   logic [BEAT_W-1:0]             beats;
   logic [BEAT_W-1:0]             issued;
   logic [LANES-1:0]              last_keep;
   logic [NUM_CHANNELS_WIDTH-1:0] nch_q;
   logic [NUM_CHANNELS_WIDTH-1:0] ch_cnt;
   logic                          user_en;

   logic [BEAT_W-1:0]             beats_calc;
   logic [SIZE_WIDTH-1:0]         size_rem;
   logic [LANES-1:0]              keep_calc;

   logic [SRAM_LATENCY-1:0]       pipe_vld;
   tag_t                          tag_pipe [SRAM_LATENCY];
   tag_t                          issue_tag;
   logic                          issue_last;
   logic [CH_W-1:0]               ch_sum;
   logic [NUM_CHANNELS_WIDTH-1:0] ch_next;

   entry_t                        mem [FIFO_DEPTH];
   entry_t                        push_entry;
   entry_t                        head;
   logic [PTR_W-1:0]              wr_ptr;
   logic [PTR_W-1:0]              rd_ptr;
   logic [CNT_W-1:0]              fifo_count;
   logic [OCC_W-1:0]              inflight;
   logic [OCC_W-1:0]              occupancy;
   logic                          push;
   logic                          pop;

   // Job geometry derived from out_size at accept time.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      keep_calc  = '0;
      beats_calc = (BEAT_W'(out_size) + BEAT_W'(LANES - 1)) >> LANE_SHIFT;
      size_rem   = out_size & SIZE_WIDTH'(LANES - 1);
      for (int i = 0; i < LANES; i++)
         keep_calc[i] = (size_rem == '0) || (SIZE_WIDTH'(i) < size_rem);
   end

   // Credit rule: words already queued plus words still in the SRAM pipe must fit the FIFO.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < SRAM_LATENCY; i++)
         inflight = inflight + OCC_W'(pipe_vld[i]);
   end

   assign occupancy    = OCC_W'(fifo_count) + inflight - OCC_W'(pop);
   assign sram_rd_en   = (state == S_RUN) && (occupancy < OCC_W'(FIFO_DEPTH));
   assign sram_rd_addr = rd_addr;
   assign busy         = (state != S_IDLE);

   // Channel counter only ever needs one subtract because it stays below num_channels >= LANES.
   assign ch_sum  = CH_W'(ch_cnt) + CH_W'(LANES);
   assign ch_next = NUM_CHANNELS_WIDTH'((ch_sum >= CH_W'(nch_q)) ? ch_sum - CH_W'(nch_q) : ch_sum);

   assign issue_last     = (issued == beats - BEAT_W'(1));
   assign issue_tag.last = issue_last;
   assign issue_tag.keep = issue_last ? last_keep : '1;
   assign issue_tag.user = user_en ? ch_cnt : '0;

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         state     <= S_IDLE;
         rd_addr   <= '0;
         beats     <= '0;
         issued    <= '0;
         last_keep <= '0;
         nch_q     <= '0;
         ch_cnt    <= '0;
         user_en   <= 1'b0;
         done      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (out_size == '0) begin
                     done <= 1'b1;
                  end else begin
                     rd_addr   <= base_addr;
                     beats     <= beats_calc;
                     issued    <= '0;
                     last_keep <= keep_calc;
                     nch_q     <= num_channels;
                     ch_cnt    <= '0;
                     user_en   <= (CH_W'(num_channels) >= CH_W'(LANES)) && (num_channels != '0);
                     state     <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (sram_rd_en) begin
                  rd_addr <= rd_addr + ADDR_WIDTH'(1);
                  issued  <= issued + BEAT_W'(1);
                  ch_cnt  <= ch_next;
                  if (issue_last)
                     state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (pop && head.last) begin
                  done  <= 1'b1;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Read-latency pipe: valid bits are reset, tags ride alongside and are only used when valid.
   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         pipe_vld <= '0;
      end else begin
         pipe_vld[0] <= sram_rd_en;
         for (int i = 1; i < SRAM_LATENCY; i++)
            pipe_vld[i] <= pipe_vld[i-1];
      end
   end

   always_ff @(posedge m_axis_aclk) begin
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < SRAM_LATENCY; i++)
         tag_pipe[i] <= tag_pipe[i-1];
   end

   assign push = pipe_vld[SRAM_LATENCY-1];

   // Masked lanes of the final beat are forced to zero before they enter the FIFO.
   always_comb begin
      push_entry      = '0;
      push_entry.keep = tag_pipe[SRAM_LATENCY-1].keep;
      push_entry.last = tag_pipe[SRAM_LATENCY-1].last;
      push_entry.user = tag_pipe[SRAM_LATENCY-1].user;
      for (int i = 0; i < LANES; i++)
         push_entry.data[i*DATA_WIDTH +: DATA_WIDTH] =
            tag_pipe[SRAM_LATENCY-1].keep[i] ? sram_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
   end

   // NOTE: FIFO storage has no reset; an entry is only visible once fifo_count covers it.
   always_ff @(posedge m_axis_aclk) begin
      if (push)
         mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
      if (!m_axis_aresetn) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign head          = mem[rd_ptr];
   assign m_axis_tvalid = (fifo_count != '0);
   assign pop           = m_axis_tvalid && m_axis_tready;

   // Payload is gated by tvalid so every output reads zero while the FIFO is empty or in reset.
   assign m_axis_tdata = m_axis_tvalid ? head.data : '0;
   assign m_axis_tkeep = m_axis_tvalid ? head.keep : '0;
   assign m_axis_tlast = m_axis_tvalid ? head.last : 1'b0;
   assign m_axis_tuser = m_axis_tvalid ? head.user : '0;

endmodule

// File: tb/tb_axis_sram_reader.sv
// Self-checking bench for axis_sram_reader: random SRAM contents, a queue-based reference of the
// expected beats and read addresses, and a negedge monitor that scores every handshake.
module tb_axis_sram_reader;

   localparam int AW    = 13;
   localparam int DW    = 8;
   localparam int LANES = 4;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;
   localparam int NCW   = 7;
   localparam int SW    = AW + $clog2(LANES) + 1;
   localparam int WW    = DW * LANES;

   typedef struct packed {
      logic [WW-1:0]    data;
      logic [LANES-1:0] keep;
      logic             last;
      logic [NCW-1:0]   user;
   } beat_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [AW-1:0]   base_addr = '0;
   logic [SW-1:0]   out_size = '0;
   logic [NCW-1:0]  num_channels = '0;
   logic            busy, done, sram_rd_en;
   logic [AW-1:0]   sram_rd_addr;
   logic [WW-1:0]   sram_rd_data;
   logic [WW-1:0]   m_axis_tdata;
   logic [LANES-1:0] m_axis_tkeep;
   logic            m_axis_tvalid, m_axis_tlast;
   logic            m_axis_tready = 1'b1;
   logic [NCW-1:0]  m_axis_tuser;

   int n_checks = 0;
   int n_pass   = 0;
   int ready_mode = 0;

   beat_t exp_q[$];
   int    exp_addr_q[$];

   logic [WW-1:0] sram [1<<AW];
   logic [WW-1:0] rd_pipe [LAT];

   axis_sram_reader #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANES(LANES), .SRAM_LATENCY(LAT),
      .FIFO_DEPTH(DEPTH), .NUM_CHANNELS_WIDTH(NCW), .SIZE_WIDTH(SW)
   ) dut (
      .m_axis_aclk(clk), .m_axis_aresetn(rst_n), .start(start), .base_addr(base_addr),
      .out_size(out_size), .num_channels(num_channels), .busy(busy), .done(done),
      .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser)
   );

   initial forever #5 clk = ~clk;

   // SRAM with LAT cycles of read latency; unread cycles return noise.
   always @(posedge clk) begin
      rd_pipe[0] <= sram_rd_en ? sram[sram_rd_addr] : WW'($urandom);
      for (int i = 1; i < LAT; i++)
         rd_pipe[i] <= rd_pipe[i-1];
   end
   assign sram_rd_data = rd_pipe[LAT-1];

   initial forever begin
      @(posedge clk); #1;
      case (ready_mode)
         0:       m_axis_tready = 1'b1;
         1:       m_axis_tready = 1'($urandom_range(0, 1));
         default: m_axis_tready = 1'b0;
      endcase
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
   endtask

   // Reference: beat k carries SRAM word (base+k) mod 2^AW, tuser = (k*LANES) mod nc.
   task automatic issue_job(input int base, input int size, input int nc);
      int    nb;
      int    rem;
      beat_t b;
      logic [WW-1:0] w;
      nb  = (size + LANES - 1) / LANES;
      rem = size % LANES;
      for (int k = 0; k < nb; k++) begin
         w      = sram[(base + k) % (1 << AW)];
         b.last = (k == nb - 1);
         b.keep = (b.last && rem != 0) ? LANES'((1 << rem) - 1) : '1;
         b.data = '0;
         for (int l = 0; l < LANES; l++)
            if (b.keep[l]) b.data[l*DW +: DW] = w[l*DW +: DW];
         b.user = '0;
         if (nc >= LANES && nc > 0) b.user = NCW'((k * LANES) % nc);
         exp_q.push_back(b);
         exp_addr_q.push_back((base + k) % (1 << AW));
      end
      @(posedge clk); #1;
      start = 1'b1; base_addr = AW'(base); out_size = SW'(size); num_channels = NCW'(nc);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic pulse_start(input int base, input int size);
      @(posedge clk); #1;
      start = 1'b1; base_addr = AW'(base); out_size = SW'(size);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Monitor model state
   logic  mbusy = 1'b0;
   logic  done_due = 1'b0;
   logic  stall_prev = 1'b0;
   logic [43:0] stall_beat = '0;
   int    n_issued = 0;
   int    n_popped = 0;

   task automatic wait_idle(input string name);
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk); #1;
         if (!mbusy && !done_due && exp_q.size() == 0 && exp_addr_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_complete"}, 64'(ok), 64'd1);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         mbusy = 1'b0; done_due = 1'b0; stall_prev = 1'b0; n_issued = 0; n_popped = 0;
      end else begin
         bit    hs;
         beat_t e;
         hs = m_axis_tvalid && m_axis_tready;
         check("busy", 64'(busy), 64'(mbusy));
         check("done", 64'(done), 64'(done_due));
         done_due = 1'b0;
         if (stall_prev) begin
            check("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
            check("stall_beat", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}),
                  64'(stall_beat));
         end
         if (sram_rd_en) begin
            check("read_expected", 64'(exp_addr_q.size() > 0), 64'd1);
            if (exp_addr_q.size() > 0) check("rd_addr", 64'(sram_rd_addr), 64'(exp_addr_q.pop_front()));
            check("fifo_credit", 64'((n_issued - n_popped + 1 - int'(hs)) <= DEPTH), 64'd1);
            n_issued++;
         end
         if (hs) begin
            check("beat_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("tdata", 64'(m_axis_tdata), 64'(e.data));
               check("tkeep", 64'(m_axis_tkeep), 64'(e.keep));
               check("tlast", 64'(m_axis_tlast), 64'(e.last));
               check("tuser", 64'(m_axis_tuser), 64'(e.user));
               if (e.last) begin
                  done_due = 1'b1;
                  mbusy    = 1'b0;
               end
            end
            n_popped++;
         end
         if (start && !mbusy) begin
            if (out_size == '0) done_due = 1'b1;
            else mbusy = 1'b1;
         end
         stall_prev = m_axis_tvalid && !m_axis_tready;
         stall_beat = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_rd, first_v, last_hs, done_cyc;
      for (int i = 0; i < (1 << AW); i++) sram[i] = WW'($urandom);

      // Reset state
      #12;
      check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_tdata", 64'(m_axis_tdata), 64'd0);
      check("rst_busy_done", 64'({busy, done}), 64'd0);
      check("rst_rd", 64'({sram_rd_en, sram_rd_addr}), 64'd0);
      @(posedge clk); #1; rst_n = 1'b1;

      // 16 elements, tready high: latency, no bubbles, done timing
      first_rd = -1; first_v = -1; last_hs = -1; done_cyc = -1;
      issue_job(200, 16, 12);
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if (sram_rd_en && first_rd < 0) first_rd = c;
         if (m_axis_tvalid && first_v < 0) first_v = c;
         if (m_axis_tvalid && m_axis_tready) last_hs = c;
         if (done && done_cyc < 0) done_cyc = c;
      end
      check("first_rd_cycle", 64'(first_rd), 64'd1);
      check("first_tvalid_cycle", 64'(first_v), 64'(2 + LAT));
      check("no_bubbles", 64'(last_hs - first_v), 64'd3);
      check("done_cycle", 64'(done_cyc), 64'(last_hs + 1));
      wait_idle("size16");

      // Partial last beat
      issue_job(1000, 10, 12);
      wait_idle("size10");

      // Zero-size job: done next cycle, no beats
      issue_job(50, 0, 12);
      @(negedge clk);
      check("zero_done", 64'(done), 64'd1);
      repeat (6) begin
         @(negedge clk);
         check("zero_no_tvalid", 64'(m_axis_tvalid), 64'd0);
      end
      wait_idle("size0");

      // Address wrap
      issue_job(8190, 16, 12);
      wait_idle("wrap");

      // Channel tagging variants
      issue_job(3000, 32, 12);
      wait_idle("nc12");
      issue_job(3100, 16, 2);
      wait_idle("nc2");
      issue_job(3200, 16, 0);
      wait_idle("nc0");

      // Backpressure: random tready over 256 elements
      ready_mode = 1;
      issue_job(7000, 256, 10);
      wait_idle("stall256");

      // start while busy is ignored
      issue_job(500, 80, 9);
      repeat (8) @(posedge clk);
      pulse_start(7, 0);
      pulse_start(9, 12);
      wait_idle("ignored_start");

      // Random jobs
      for (int j = 0; j < 8; j++) begin
         ready_mode = int'($urandom_range(0, 1));
         issue_job(int'($urandom_range(0, 8191)), int'($urandom_range(0, 300)),
                   int'($urandom_range(0, 127)));
         wait_idle("random");
      end

      // Reset mid-run with beats held in the FIFO
      ready_mode = 2;
      issue_job(100, 64, 12);
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("midrst_payload", 64'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 64'd0);
      check("midrst_ctrl", 64'({busy, done, sram_rd_en}), 64'd0);
      check("midrst_addr", 64'(sram_rd_addr), 64'd0);
      exp_q.delete();
      exp_addr_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      ready_mode = 0;
      issue_job(4000, 22, 8);
      wait_idle("after_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
